// File: rtl/si_alien_march_ctrl.sv
// si_alien_march_ctrl: load/shift/clear sequencer for one alien-row shift register.
// Optional macro SI_ALIENMARCH_SPEEDUP_EN shortens the step period on every descend.
module si_alien_march_ctrl #(
  parameter int unsigned                MARCH_DATAWIDTH    = 8,
  parameter int unsigned                MARCH_STEP_DIV     = 4,
  parameter logic [MARCH_DATAWIDTH-1:0] MARCH_INIT_PATTERN = 8'b0011_1100,
  parameter int unsigned                MARCH_STEP_MIN     = 2,
  parameter int unsigned                MARCH_STEP_DEC     = 1
) (
  input  logic                       SC_AlienMARCH_CLOCK_50,
  input  logic                       SC_AlienMARCH_RESET_InLow,
  input  logic                       SC_AlienMARCH_start_InLow,
  input  logic                       SC_AlienMARCH_stop_InLow,
  input  logic                       SC_AlienMARCH_enable_In,
  input  logic [MARCH_DATAWIDTH-1:0] SC_AlienMARCH_row_InBUS,
  output logic [1:0]                 SC_AlienMARCH_shiftselection_Out,
  output logic                       SC_AlienMARCH_load_OutLow,
  output logic                       SC_AlienMARCH_clear_OutLow,
  output logic [MARCH_DATAWIDTH-1:0] SC_AlienMARCH_pattern_OutBUS,
  output logic                       SC_AlienMARCH_descend_Out,
  output logic                       SC_AlienMARCH_rowclear_Out,
  output logic                       SC_AlienMARCH_busy_Out
);

  localparam int unsigned CNT_W = $clog2(MARCH_STEP_DIV + 1);
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(MARCH_STEP_DIV);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] SHIFT   = 3'd4;
  localparam logic [2:0] DESCEND = 3'd5;
  localparam logic [2:0] CLEAR   = 3'd6;

  localparam logic [1:0] DIR_MSB = 2'b01;
  localparam logic [1:0] DIR_LSB = 2'b10;

  if (MARCH_STEP_DIV < 1) begin : g_bad_div
    $error("MARCH_STEP_DIV must be at least 1");
  end
  if (MARCH_STEP_MIN < 1 || MARCH_STEP_MIN > MARCH_STEP_DIV || MARCH_STEP_DEC < 1) begin : g_bad_speed
    $error("MARCH_STEP_MIN must lie in 1..MARCH_STEP_DIV and MARCH_STEP_DEC must be non-zero");
  end

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [1:0]       dir;
  logic [1:0]       dir_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] period;
  logic             abort;
  logic             at_edge;

`ifdef SI_ALIENMARCH_SPEEDUP_EN
  logic [CNT_W-1:0] period_next;

  // Saturating decrement: never drop below the floor, never wrap.
  function automatic logic [CNT_W-1:0] sat_period(input logic [CNT_W-1:0] p);
    if (32'(p) <= MARCH_STEP_MIN + MARCH_STEP_DEC)
      return CNT_W'(MARCH_STEP_MIN);
    else
      return p - CNT_W'(MARCH_STEP_DEC);
  endfunction

  always_ff @(posedge SC_AlienMARCH_CLOCK_50 or negedge SC_AlienMARCH_RESET_InLow) begin
    if (!SC_AlienMARCH_RESET_InLow)
      period <= DIV_C;
    else
      period <= period_next;
  end
`else
  assign period = DIV_C;
`endif

  // Stop wins over everything once a wave is running; CLEAR itself always exits.
  assign abort = !SC_AlienMARCH_stop_InLow && (state != IDLE) && (state != CLEAR);

  assign at_edge = ((dir == DIR_LSB) && SC_AlienMARCH_row_InBUS[0]) ||
                   ((dir == DIR_MSB) && SC_AlienMARCH_row_InBUS[MARCH_DATAWIDTH-1]);

  always_comb begin
    state_next = state;
    dir_next   = dir;
    cnt_next   = cnt;
`ifdef SI_ALIENMARCH_SPEEDUP_EN
    period_next = period;
`endif
    if (abort) begin
      state_next = CLEAR;
    end else begin
      case (state)
        IDLE: begin
          if (!SC_AlienMARCH_start_InLow && SC_AlienMARCH_stop_InLow)
            state_next = LOAD;
        end
        LOAD: begin
          dir_next   = DIR_LSB;
          cnt_next   = DIV_C - 1'b1;
`ifdef SI_ALIENMARCH_SPEEDUP_EN
          period_next = DIV_C;
`endif
          state_next = WAIT;
        end
        WAIT: begin
          if (SC_AlienMARCH_enable_In) begin
            if (cnt == '0)
              state_next = CHECK;
            else
              cnt_next = cnt - 1'b1;
          end
        end
        CHECK: begin
          if (SC_AlienMARCH_row_InBUS == '0)
            state_next = CLEAR;
          else if (at_edge)
            state_next = DESCEND;
          else
            state_next = SHIFT;
        end
        SHIFT: begin
          cnt_next   = period - 1'b1;
          state_next = WAIT;
        end
        DESCEND: begin
          dir_next = {dir[0], dir[1]};
`ifdef SI_ALIENMARCH_SPEEDUP_EN
          // The shortened period already governs this reload.
          period_next = sat_period(period);
          cnt_next    = sat_period(period) - 1'b1;
`else
          cnt_next    = period - 1'b1;
`endif
          state_next = WAIT;
        end
        CLEAR: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge SC_AlienMARCH_CLOCK_50 or negedge SC_AlienMARCH_RESET_InLow) begin
    if (!SC_AlienMARCH_RESET_InLow) begin
      state <= IDLE;
      dir   <= DIR_LSB;
      cnt   <= '0;
    end else begin
      state <= state_next;
      dir   <= dir_next;
      cnt   <= cnt_next;
    end
  end

  // Moore decode: each strobe belongs to exactly one state, so they never overlap.
  assign SC_AlienMARCH_shiftselection_Out = (state == SHIFT) ? dir : 2'b00;
  assign SC_AlienMARCH_load_OutLow        = (state != LOAD);
  assign SC_AlienMARCH_clear_OutLow       = (state != CLEAR);
  assign SC_AlienMARCH_pattern_OutBUS     = MARCH_INIT_PATTERN;
  assign SC_AlienMARCH_descend_Out        = (state == DESCEND);
  assign SC_AlienMARCH_rowclear_Out       = (state == CLEAR);
  assign SC_AlienMARCH_busy_Out           = (state != IDLE);

endmodule

// File: tb/tb_si_alien_march_ctrl.sv
// Bench for si_alien_march_ctrl: directed literal checks plus a randomized run
// against a queue-of-planned-actions reference model, with a model shift register as feedback.
module tb_si_alien_march_ctrl;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int MIN = 2;
  localparam int DEC = 1;
  localparam logic [7:0] PAT = 8'h3C;

  localparam int A_IDLE  = -1;
  localparam int A_LOAD  = 0;
  localparam int A_WAIT  = 1;
  localparam int A_CHECK = 2;
  localparam int A_SH10  = 3;
  localparam int A_SH01  = 4;
  localparam int A_DESC  = 5;
  localparam int A_CLEAR = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b1;
  logic       stop = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] row;
  logic [7:0] row_upd;
  logic [7:0] hit_mask = 8'h00;
  logic [1:0] shsel;
  logic       load;
  logic       clear;
  logic [7:0] pattern;
  logic       descend;
  logic       rowclear;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int         plan[$];
  logic [1:0] m_dir = 2'b10;
  int         m_period = DIV;

  always #5 clk = ~clk;

  si_alien_march_ctrl #(
    .MARCH_DATAWIDTH(W), .MARCH_STEP_DIV(DIV), .MARCH_INIT_PATTERN(PAT),
    .MARCH_STEP_MIN(MIN), .MARCH_STEP_DEC(DEC)
  ) dut (
    .SC_AlienMARCH_CLOCK_50(clk),
    .SC_AlienMARCH_RESET_InLow(rst_n),
    .SC_AlienMARCH_start_InLow(start),
    .SC_AlienMARCH_stop_InLow(stop),
    .SC_AlienMARCH_enable_In(enable),
    .SC_AlienMARCH_row_InBUS(row),
    .SC_AlienMARCH_shiftselection_Out(shsel),
    .SC_AlienMARCH_load_OutLow(load),
    .SC_AlienMARCH_clear_OutLow(clear),
    .SC_AlienMARCH_pattern_OutBUS(pattern),
    .SC_AlienMARCH_descend_Out(descend),
    .SC_AlienMARCH_rowclear_Out(rowclear),
    .SC_AlienMARCH_busy_Out(busy)
  );

  // Alien-row register driven by the controller's strobes; hit_mask knocks out aliens.
  always_comb begin
    row_upd = row;
    if (!load)                row_upd = pattern;
    else if (!clear)          row_upd = 8'h00;
    else if (shsel == 2'b01)  row_upd = row << 1;
    else if (shsel == 2'b10)  row_upd = row >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row <= 8'h00;
    else        row <= row_upd & ~hit_mask;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] lit(input logic [1:0] sh, input logic ld, input logic cl,
                                      input logic de, input logic rc, input logic bz);
    return {sh, ld, cl, PAT, de, rc, bz};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {shsel, load, clear, pattern, descend, rowclear, busy};
  endfunction

  function automatic int head();
    return (plan.size() > 0) ? plan[0] : A_IDLE;
  endfunction

  function automatic logic [14:0] model_vec();
    int h;
    logic [1:0] sh;
    h  = head();
    sh = (h == A_SH10) ? 2'b10 : (h == A_SH01) ? 2'b01 : 2'b00;
    return lit(sh, h != A_LOAD, h != A_CLEAR, h == A_DESC, h == A_CLEAR, h != A_IDLE);
  endfunction

  function automatic int dut_code();
    if (descend)             return A_DESC;
    if (!clear)              return A_CLEAR;
    if (shsel == 2'b10)      return A_SH10;
    if (shsel == 2'b01)      return A_SH01;
    return A_IDLE;
  endfunction

  task automatic push_step(input int per);
    for (int i = 0; i < per; i++) plan.push_back(A_WAIT);
    plan.push_back(A_CHECK);
  endtask

  // Consume the current cycle's planned action and extend the plan from the inputs.
  task automatic model_advance();
    int h;
    if (!rst_n) begin
      plan.delete();
      return;
    end
    if (plan.size() == 0) begin
      if (!start && stop) begin
        m_dir = 2'b10;
        m_period = DIV;
        plan.push_back(A_LOAD);
        push_step(m_period);
      end
    end else if (!stop && plan[0] != A_CLEAR) begin
      plan.delete();
      plan.push_back(A_CLEAR);
    end else if (plan[0] == A_WAIT && !enable) begin
    end else begin
      h = plan.pop_front();
      if (h == A_CHECK) begin
        if (row == 8'h00) begin
          plan.push_back(A_CLEAR);
        end else if ((m_dir == 2'b10 && row[0]) || (m_dir == 2'b01 && row[7])) begin
          plan.push_back(A_DESC);
          m_dir = (m_dir == 2'b10) ? 2'b01 : 2'b10;
`ifdef SI_ALIENMARCH_SPEEDUP_EN
          m_period = (m_period - DEC < MIN) ? MIN : m_period - DEC;
`endif
          push_step(m_period);
        end else begin
          plan.push_back((m_dir == 2'b10) ? A_SH10 : A_SH01);
          push_step(m_period);
        end
      end
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    chk("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (shsel != 2'b00 || descend || !clear) return;
    end
    checks++;
    failures++;
    $display("FAIL strobe_timeout actual=none required=strobe_within_40_cycles");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int exp_code[9] = '{A_SH10, A_SH10, A_DESC, A_SH01, A_SH01, A_SH01, A_SH01, A_DESC, A_SH10};
`ifdef SI_ALIENMARCH_SPEEDUP_EN
    int exp_gap[9] = '{6, 6, 6, 5, 5, 5, 5, 5, 4};
    int pause_gap = 14;
`else
    int exp_gap[9] = '{6, 6, 6, 6, 6, 6, 6, 6, 6};
    int pause_gap = 16;
`endif

    repeat (3) begin
      tick();
      chk("reset_outputs", 32'(dut_vec()), 32'(lit(2'b00, 1, 1, 0, 0, 0)));
    end
    rst_n = 1'b1;
    tick();
    chk("after_reset_idle", 32'(dut_vec()), 32'(lit(2'b00, 1, 1, 0, 0, 0)));

    start = 1'b0;
    tick();
    chk("load_strobe", 32'(dut_vec()), 32'(lit(2'b00, 0, 1, 0, 0, 1)));
    chk("model_pin_load", 32'(model_vec()), 32'(lit(2'b00, 0, 1, 0, 0, 1)));
    start = 1'b1;

    for (int k = 0; k < 9; k++) begin
      wait_strobe(n);
      chk($sformatf("step%0d_code", k), 32'(dut_code()), 32'(exp_code[k]));
      chk($sformatf("step%0d_gap", k), 32'(n), 32'(exp_gap[k]));
    end
    chk("model_pin_shift", 32'(model_vec()), 32'(lit(2'b10, 1, 1, 0, 0, 1)));

    tick();
    enable = 1'b0;
    repeat (10) begin
      tick();
      chk("pause_no_strobe", 32'(dut_vec()), 32'(lit(2'b00, 1, 1, 0, 0, 1)));
    end
    enable = 1'b1;
    wait_strobe(n);
    chk("pause_gap", 32'(n + 11), 32'(pause_gap));
    chk("pause_code", 32'(dut_code()), 32'(A_SH10));

    tick();
    hit_mask = 8'hFF;
    tick();
    hit_mask = 8'h00;
    wait_strobe(n);
    chk("empty_row_clear", 32'(dut_vec()), 32'(lit(2'b00, 1, 0, 0, 1, 1)));
    tick();
    chk("empty_row_idle", 32'(dut_vec()), 32'(lit(2'b00, 1, 1, 0, 0, 0)));

    start = 1'b0;
    stop  = 1'b0;
    tick();
    chk("stop_beats_start", 32'(dut_vec()), 32'(lit(2'b00, 1, 1, 0, 0, 0)));
    stop = 1'b1;
    tick();
    chk("second_load", 32'(dut_vec()), 32'(lit(2'b00, 0, 1, 0, 0, 1)));
    start = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    tick();
    chk("abort_clear", 32'(dut_vec()), 32'(lit(2'b00, 1, 0, 0, 1, 1)));
    stop  = 1'b1;
    start = 1'b0;
    tick();
    chk("abort_idle", 32'(dut_vec()), 32'(lit(2'b00, 1, 1, 0, 0, 0)));
    tick();
    chk("restart_load", 32'(dut_vec()), 32'(lit(2'b00, 0, 1, 0, 0, 1)));
    start = 1'b1;

    wait_strobe(n);
    chk("pre_reset_shift", 32'(shsel), 32'(2'b10));
    #1 rst_n = 1'b0;
    #1 chk("async_reset_shift", 32'(dut_vec()), 32'(lit(2'b00, 1, 1, 0, 0, 0)));
    tick();
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      stop   = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 299) == 0)
        hit_mask = 8'hFF;
      else if ($urandom_range(0, 11) == 0)
        hit_mask = 8'(1 << $urandom_range(0, 7));
      else
        hit_mask = 8'h00;
      tick();
    end
    hit_mask = 8'h00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
